// File: rtl/output_result_divq.sv
// Fully pipelined unsigned restoring divider with an output stage that
// rounds (optionally), saturates to QUOT_W bits and flags division by zero.
// A new operand pair is accepted every clock; results leave in issue order
// DIVIDEND_W+1 clocks after StartIn is sampled.
module output_result_divq #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 20,
  parameter int QUOT_W     = 8,
  parameter int ROUND_EN   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DIVIDEND_W-1:0] DataIn,
  input  logic                  StartIn,
  input  logic [DIVISOR_W-1:0]  Divisor,
  output logic                  StartOut,
  output logic [QUOT_W-1:0]     DataOut,
  output logic                  Sat,
  output logic                  Div0
);

  localparam int DW = DIVIDEND_W;
  localparam int VW = DIVISOR_W;

  // Largest representable output value, widened to the rounded-quotient width.
  localparam logic [DW:0] QMAX = {{(DW + 1 - QUOT_W){1'b0}}, {QUOT_W{1'b1}}};

  // Rank 0 holds the captured operands; rank i holds the state after i
  // quotient bits have been resolved. The qd word starts as the dividend and
  // is shifted left each stage, the freshly decided quotient bit entering at
  // the bottom, so after DW stages it holds the full quotient.
  logic          vld     [0:DW];
  logic [DW-1:0] qd      [0:DW];
  logic [VW:0]   rem     [0:DW];
  logic [VW-1:0] dvs     [0:DW];

  logic [DW-1:0] qd_nxt  [1:DW];
  logic [VW:0]   rem_nxt [1:DW];

  logic [DW:0]       q_round;
  logic              round_up;
  logic              div0_c;
  logic              sat_c;
  logic [QUOT_W-1:0] data_c;

  // One restoring-division step per stage: bring down the next dividend bit,
  // subtract the divisor when it fits and record the quotient bit.
  always_comb begin
    logic [VW:0] trial;
    logic        take;
    trial = '0;
    take  = 1'b0;
    for (int i = 1; i <= DW; i++) begin
      // The remainder entering a stage is always below the divisor, so its
      // top bit is zero and dropping it before the shift loses nothing.
      trial      = {rem[i-1][VW-1:0], qd[i-1][DW-1]};
      take       = (trial >= {1'b0, dvs[i-1]});
      rem_nxt[i] = take ? (trial - {1'b0, dvs[i-1]}) : trial;
      qd_nxt[i]  = {qd[i-1][DW-2:0], take};
    end
  end

  // Valid token pipeline; reset empties every stage so nothing in flight
  // can reach the output after reset is released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= DW; i++) vld[i] <= 1'b0;
    end else begin
      vld[0] <= StartIn;
      for (int i = 1; i <= DW; i++) vld[i] <= vld[i-1];
    end
  end

  // Arithmetic datapath; each stage keeps its own divisor copy so that
  // back-to-back operands never share state.
  // NOTE: the datapath is deliberately left out of reset -- the valid bits
  // alone decide whether a rank's contents are meaningful, and keeping reset
  // off this wide register array lets it map to plain flops.
  always_ff @(posedge clock) begin
    qd[0]  <= DataIn;
    rem[0] <= '0;
    dvs[0] <= Divisor;
    for (int i = 1; i <= DW; i++) begin
      qd[i]  <= qd_nxt[i];
      rem[i] <= rem_nxt[i];
      dvs[i] <= dvs[i-1];
    end
  end

  // Round half-up on the full-width quotient, then clip or flag div-by-zero.
  always_comb begin
    round_up = (ROUND_EN != 0) && ({rem[DW], 1'b0} >= {2'b00, dvs[DW]});
    q_round  = {1'b0, qd[DW]} + {{DW{1'b0}}, round_up};
    div0_c   = (dvs[DW] == '0);
    sat_c    = !div0_c && (q_round > QMAX);
    data_c   = (div0_c || sat_c) ? {QUOT_W{1'b1}} : q_round[QUOT_W-1:0];
  end

  // Output stage: strobe every valid token, and hold the result fields
  // between strobes.
  // NOTE: non-blocking assignments here and in every clocked block, so each
  // register samples the value from before the edge regardless of block order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      StartOut <= 1'b0;
      DataOut  <= '0;
      Sat      <= 1'b0;
      Div0     <= 1'b0;
    end else begin
      StartOut <= vld[DW];
      if (vld[DW]) begin
        DataOut <= data_c;
        Sat     <= sat_c;
        Div0    <= div0_c;
      end
    end
  end

endmodule

// File: tb/tb_output_result_divq.sv
// Self-checking bench for output_result_divq. Two instances share stimulus:
// one rounding (default) and one truncating. Expected results come from a
// table of hand-derived values and from a plain-arithmetic reference model,
// and are matched in issue order against every StartOut strobe.
module tb_output_result_divq;

  localparam int LAT = 29;

  logic        clock;
  logic        reset_n;
  logic [27:0] DataIn;
  logic        StartIn;
  logic [19:0] Divisor;

  logic        StartOut,   StartOut_t;
  logic [7:0]  DataOut,    DataOut_t;
  logic        Sat,        Sat_t;
  logic        Div0,       Div0_t;

  output_result_divq u_dut (
    .clock(clock), .reset_n(reset_n), .DataIn(DataIn), .StartIn(StartIn),
    .Divisor(Divisor), .StartOut(StartOut), .DataOut(DataOut), .Sat(Sat),
    .Div0(Div0)
  );

  output_result_divq #(.ROUND_EN(0)) u_dut_trunc (
    .clock(clock), .reset_n(reset_n), .DataIn(DataIn), .StartIn(StartIn),
    .Divisor(Divisor), .StartOut(StartOut_t), .DataOut(DataOut_t), .Sat(Sat_t),
    .Div0(Div0_t)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    longint q;
    longint qt;
    bit     sat;
    bit     satt;
    bit     dz;
    int     issue_cyc;
  } exp_t;

  typedef struct {
    longint a;
    longint d;
    longint q;
    longint qt;
    bit     sat;
    bit     satt;
    bit     dz;
  } vec_t;

  exp_t   exp_q[$];
  exp_t   e;
  longint last_q, last_qt;
  bit     last_sat, last_satt, last_dz;

  // Reference: exact quotient by integer division, then the rounding,
  // saturation and zero-divisor rules applied directly.
  function automatic void ref_div(input longint a, input longint d, input bit rnd,
                                  output longint q, output bit sat, output bit dz);
    longint r;
    if (d == 0) begin
      q = 255; sat = 1'b0; dz = 1'b1;
    end else begin
      q  = a / d;
      r  = a % d;
      dz = 1'b0;
      if (rnd && (2 * r >= d)) q = q + 1;
      sat = (q > 255);
      if (sat) q = 255;
    end
  endfunction

  task automatic drive(input bit s, input longint a, input longint d);
    StartIn = s;
    DataIn  = 28'(a);
    Divisor = 20'(d);
  endtask

  task automatic push(input longint q, input longint qt, input bit sat,
                      input bit satt, input bit dz);
    exp_t x;
    x.q = q; x.qt = qt; x.sat = sat; x.satt = satt; x.dz = dz;
    x.issue_cyc = cyc + 1;
    exp_q.push_back(x);
  endtask

  task automatic issue_model(input longint a, input longint d);
    longint q, qt;
    bit sat, satt, dz, dzt;
    ref_div(a, d, 1'b1, q, sat, dz);
    ref_div(a, d, 1'b0, qt, satt, dzt);
    drive(1'b1, a, d);
    push(q, qt, sat, satt, dz);
  endtask

  always @(negedge reset_n) begin
    exp_q.delete();
    last_q = 0; last_qt = 0; last_sat = 0; last_satt = 0; last_dz = 0;
  end

  // Scoreboard: every strobe must match the oldest outstanding operand at
  // the exact latency; between strobes the result fields must hold.
  always @(negedge clock) begin
    if (reset_n) begin
      if (StartOut) begin
        if (exp_q.size() == 0) begin
          check("spurious_startout", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency",    cyc - e.issue_cyc, LAT);
          check("data_round", DataOut, e.q);
          check("sat_round",  Sat, e.sat);
          check("div0",       Div0, e.dz);
          check("startout_trunc", StartOut_t, 1);
          check("data_trunc", DataOut_t, e.qt);
          check("sat_trunc",  Sat_t, e.satt);
          check("div0_trunc", Div0_t, e.dz);
          last_q = e.q; last_qt = e.qt; last_sat = e.sat;
          last_satt = e.satt; last_dz = e.dz;
        end
      end else begin
        check("startout_trunc_idle", StartOut_t, 0);
        check("hold_data",  DataOut, last_q);
        check("hold_sat",   Sat, last_sat);
        check("hold_div0",  Div0, last_dz);
        check("hold_data_trunc", DataOut_t, last_qt);
        check("hold_sat_trunc",  Sat_t, last_satt);
      end
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clock);
    check(name, exp_q.size(), 0);
  endtask

  vec_t tbl[13];

  initial begin
    //           a          d        q    qt  sat satt dz
    tbl[0]  = '{1000,      10,      100, 100, 0, 0, 0};
    tbl[1]  = '{25,        10,      3,   2,   0, 0, 0};
    tbl[2]  = '{24,        10,      2,   2,   0, 0, 0};
    tbl[3]  = '{2560,      10,      255, 255, 1, 1, 0};
    tbl[4]  = '{2549,      10,      255, 254, 0, 0, 0};
    tbl[5]  = '{2555,      10,      255, 255, 1, 0, 0};
    tbl[6]  = '{500,       0,       255, 255, 0, 0, 1};
    tbl[7]  = '{40,        4,       10,  10,  0, 0, 0};
    tbl[8]  = '{10,        1,       10,  10,  0, 0, 0};
    tbl[9]  = '{20,        2,       10,  10,  0, 0, 0};
    tbl[10] = '{90,        3,       30,  30,  0, 0, 0};
    tbl[11] = '{0,         7,       0,   0,   0, 0, 0};
    tbl[12] = '{268435455, 1048575, 255, 255, 1, 1, 0};

    reset_n = 1'b0;
    drive(1'b0, 0, 0);
    repeat (3) @(negedge clock);
    check("reset_startout", StartOut, 0);
    check("reset_dataout",  DataOut, 0);

    // Table applied back-to-back, the first operand on the release edge.
    reset_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clock);
      drive(1'b1, tbl[i].a, tbl[i].d);
      push(tbl[i].q, tbl[i].qt, tbl[i].sat, tbl[i].satt, tbl[i].dz);
    end
    @(negedge clock);
    drive(1'b0, 0, 0);
    // Two spaced operands so the held value is checked across idle gaps.
    repeat (5) @(negedge clock);
    drive(1'b1, 15, 10);
    push(2, 1, 0, 0, 0);
    @(negedge clock);
    drive(1'b0, 0, 0);
    repeat (3) @(negedge clock);
    drive(1'b1, 14, 10);
    push(1, 1, 0, 0, 0);
    @(negedge clock);
    drive(1'b0, 0, 0);
    drain("drain_table");

    // Reset in flight: the operand issued before reset must never emerge.
    @(negedge clock);
    drive(1'b1, 1234, 7);
    @(negedge clock);
    drive(1'b0, 0, 0);
    repeat (9) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_startout", StartOut, 0);
    check("midreset_dataout",  DataOut, 0);
    check("midreset_sat",      Sat, 0);
    check("midreset_div0",     Div0, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      longint a, d;
      int sh, k;
      sh = $urandom_range(0, 28);
      a  = longint'($urandom) & ((64'd1 << sh) - 1);
      k  = $urandom_range(1, 20);
      d  = ($urandom_range(0, 15) == 0) ? 0 : longint'($urandom_range(1, (1 << k) - 1));
      if ($urandom_range(0, 2) != 0) issue_model(a, d);
      else drive(1'b0, a, d);
      @(negedge clock);
    end
    drive(1'b0, 0, 0);
    drain("drain_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_result_divq.md
OUTPUT_RESULT_DIVQ -- requirements
Module: output_result_divq

Interface
REQ-001 The block SHALL take parameter DIVIDEND_W, default 28, dividend width in bits.
REQ-002 The block SHALL take parameter DIVISOR_W, default 20, divisor width in bits.
REQ-003 The block SHALL take parameter QUOT_W, default 8, output quotient width; QUOT_W <= DIVIDEND_W.
REQ-004 The block SHALL take parameter ROUND_EN, default 1; 1 = round-half-up, 0 = truncate.
REQ-005 The block SHALL provide port clock  input  1  the single rising-edge clock.
REQ-006 The block SHALL provide port reset_n  input  1  reset, asynchronous and active-low.
REQ-007 The block SHALL provide port DataIn  input  DIVIDEND_W  unsigned dividend.
REQ-008 The block SHALL provide port StartIn  input  1  input-valid strobe, sampled every clock.
REQ-009 The block SHALL provide port Divisor  input  DIVISOR_W  unsigned divisor, sampled with StartIn.
REQ-010 The block SHALL provide port StartOut  output  1  one-cycle result-valid strobe.
REQ-011 The block SHALL provide port DataOut  output  QUOT_W  quotient after rounding and saturation.
REQ-012 The block SHALL provide port Sat  output  1  result clipped to 2^QUOT_W-1.
REQ-013 The block SHALL provide port Div0  output  1  divisor was zero.

Function
REQ-014 The block SHALL be fully pipelined, one quotient bit per stage, DIVIDEND_W restoring-division stages plus one output stage.
REQ-015 Latency SHALL be LAT = DIVIDEND_W+1 clocks: StartIn high at edge k yields StartOut high in the cycle after edge k+LAT (29 clocks at defaults).
REQ-016 The block SHALL accept a new operand on every clock; no stall, no backpressure, no bubble between consecutive operations.
REQ-017 Results SHALL emerge in issue order, each paired with its own operands; each stage carries its own divisor copy.
REQ-018 Cycles with StartIn low SHALL inject an invalid token; that token SHALL never raise StartOut.
REQ-019 Internal arithmetic SHALL use DIVIDEND_W-bit quotient and DIVISOR_W+1-bit partial remainder; no truncation before the output stage.
REQ-020 With ROUND_EN=1 the full quotient SHALL be incremented when 2*remainder >= Divisor; with ROUND_EN=0 it SHALL not.
REQ-021 If the rounded full quotient exceeds 2^QUOT_W-1, DataOut SHALL be 2^QUOT_W-1 and Sat SHALL be 1; else Sat SHALL be 0 and DataOut the low QUOT_W bits.
REQ-022 Divisor = 0 SHALL give DataOut = 2^QUOT_W-1, Div0 = 1, Sat = 0, at the normal latency.
REQ-023 DataIn = 0 with nonzero Divisor SHALL give DataOut = 0, Sat = 0, Div0 = 0.
REQ-024 DataOut, Sat and Div0 SHALL update only in cycles where StartOut is high and SHALL hold their values otherwise.
REQ-025 StartOut SHALL be high for exactly one cycle per accepted operand.

Reset
REQ-026 reset_n low SHALL asynchronously clear StartOut, DataOut, Sat, Div0 and every stage valid bit to 0.
REQ-027 Reset mid-operation SHALL discard all in-flight operands; no StartOut for any operand issued before reset release.
REQ-028 The first StartIn sampled at a rising edge after reset_n release SHALL be accepted normally.

Verification
REQ-029 Basic, defaults: DataIn=1000, Divisor=10, StartIn pulse -> StartOut 29 clocks later, DataOut=100, Sat=0, Div0=0.
REQ-030 Rounding: 25/10 -> DataOut=3 (ROUND_EN=1) or 2 (ROUND_EN=0); 24/10 -> 2 in both cases.
REQ-031 Saturation: 2560/10 -> DataOut=255, Sat=1; 2549/10 with ROUND_EN=1 -> 255, Sat=0; 2555/10 -> 255, Sat=1.
REQ-032 Divide-by-zero: 500/0 -> DataOut=255, Div0=1, Sat=0; next operand 40/4 -> 10, Div0=0.
REQ-033 Throughput: StartIn high 3 consecutive cycles with 10/1, 20/2, 90/3 -> StartOut high 3 consecutive cycles, DataOut 10, 10, 30 in order.
REQ-034 Reset mid-flight: StartIn at cycle 0, reset_n low at cycle 10 for 2 clocks -> outputs 0 immediately and no StartOut through cycle 40.
